// File: rtl/fpga_cfg_pkg.sv
// Shared fabric configuration for the fixed-point datapath blocks.
// Also provides divider pipeline depth helpers.
package fpga_cfg_pkg;

   localparam int FP_WIDTH   = 32;
   localparam int FP_QFRAC   = 16;
   localparam int FP_DIV_BPS = 4;

   function automatic int fx_div_nstg(int w, int q, int b);
      return (w + q + b - 1) / b;
   endfunction

   // One operand-capture stage plus one output stage around the iterations.
   function automatic int fx_div_latency(int w, int q, int b);
      return fx_div_nstg(w, q, b) + 2;
   endfunction

endpackage

// File: rtl/fx_div_stage.sv
// One registered slice of the restoring divider: BPS quotient bits per cycle.
// Dividend bits shift out the top of dq while quotient bits shift in below.
module fx_div_stage
   import fpga_cfg_pkg::*;
#(
   parameter int WIDTH = FP_WIDTH,
   parameter int NQ    = 48,
   parameter int BPS   = FP_DIV_BPS,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             v_i,
   input  logic [WIDTH-1:0] rem_i,
   input  logic [NQ-1:0]    dq_i,
   input  logic [WIDTH-1:0] den_i,
   input  logic             neg_i,
   input  logic             nneg_i,
   input  logic             dz_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             v_o,
   output logic [WIDTH-1:0] rem_o,
   output logic [NQ-1:0]    dq_o,
   output logic [WIDTH-1:0] den_o,
   output logic             neg_o,
   output logic             nneg_o,
   output logic             dz_o,
   output logic [TAG_W-1:0] tag_o
);

   logic             v_q, neg_q, nneg_q, dz_q;
   logic [WIDTH-1:0] rem_q, rem_d, den_q;
   logic [NQ-1:0]    dq_q, dq_d;
   logic [TAG_W-1:0] tag_q;
   logic [WIDTH:0]   t, diff;

   always_comb begin
      rem_d = rem_i;
      dq_d  = dq_i;
      t     = '0;
      diff  = '0;
      for (int k = 0; k < BPS; k++) begin
         t    = {rem_d, dq_d[NQ-1]};
         dq_d = {dq_d[NQ-2:0], 1'b0};
         diff = t - {1'b0, den_i};
         if (t >= {1'b0, den_i}) begin
            rem_d   = diff[WIDTH-1:0];
            dq_d[0] = 1'b1;
         end else begin
            rem_d = t[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= 1'b0;
         rem_q  <= '0;
         dq_q   <= '0;
         den_q  <= '0;
         neg_q  <= 1'b0;
         nneg_q <= 1'b0;
         dz_q   <= 1'b0;
         tag_q  <= '0;
      end else if (en_i) begin
         v_q    <= v_i;
         rem_q  <= rem_d;
         dq_q   <= dq_d;
         den_q  <= den_i;
         neg_q  <= neg_i;
         nneg_q <= nneg_i;
         dz_q   <= dz_i;
         tag_q  <= tag_i;
      end
   end

   assign v_o    = v_q;
   assign rem_o  = rem_q;
   assign dq_o   = dq_q;
   assign den_o  = den_q;
   assign neg_o  = neg_q;
   assign nneg_o = nneg_q;
   assign dz_o   = dz_q;
   assign tag_o  = tag_q;

endmodule

// File: rtl/fx_div_pipe.sv
// Pipelined signed fixed-point divider: (num << QFRAC) / den, sign-magnitude.
// Whole pipe advances on one enable; the output stage rounds and saturates.
module fx_div_pipe
   import fpga_cfg_pkg::*;
#(
   parameter int WIDTH = FP_WIDTH,
   parameter int QFRAC = FP_QFRAC,
   parameter int BPS   = FP_DIV_BPS,
   parameter int TAG_W = 8,
   parameter int ROUND = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [WIDTH-1:0] numerator,
   input  logic [WIDTH-1:0] denominator,
   input  logic [TAG_W-1:0] tag_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] tag_out,
   output logic             dz,
   output logic             ovf
);

   localparam int NSTG    = fx_div_nstg(WIDTH, QFRAC, BPS);
   localparam int NQ      = NSTG * BPS;
   localparam int LATENCY = fx_div_latency(WIDTH, QFRAC, BPS);

   localparam logic [NQ:0] POS_LIM =
      {{(NQ-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [NQ:0] NEG_LIM =
      {{(NQ-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAXR = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINR = {1'b1, {(WIDTH-1){1'b0}}};

   logic en;

   logic [WIDTH-1:0] mag_n_d, mag_d_d;
   logic [NQ-1:0]    dq0_d;

   logic             s0_v_q, s0_neg_q, s0_nneg_q, s0_dz_q;
   logic [WIDTH-1:0] s0_den_q;
   logic [NQ-1:0]    s0_dq_q;
   logic [TAG_W-1:0] s0_tag_q;

   logic [NSTG:0]    st_v, st_neg, st_nneg, st_dz;
   logic [WIDTH-1:0] st_rem [NSTG+1];
   logic [WIDTH-1:0] st_den [NSTG+1];
   logic [NQ-1:0]    st_dq  [NSTG+1];
   logic [TAG_W-1:0] st_tag [NSTG+1];

   logic             valid_out_q, dz_q, ovf_q, dz_d, ovf_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [TAG_W-1:0] tag_out_q;
   logic [NQ:0]      qr;
   logic             rnd;

   assign en        = ready_in | ~valid_out_q;
   assign ready_out = en;

   always_comb begin
      mag_n_d = numerator[WIDTH-1] ? -numerator : numerator;
      mag_d_d = denominator[WIDTH-1] ? -denominator : denominator;
      dq0_d   = NQ'(mag_n_d) << QFRAC;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_v_q    <= 1'b0;
         s0_neg_q  <= 1'b0;
         s0_nneg_q <= 1'b0;
         s0_dz_q   <= 1'b0;
         s0_den_q  <= '0;
         s0_dq_q   <= '0;
         s0_tag_q  <= '0;
      end else if (en) begin
         s0_v_q    <= valid_in;
         s0_neg_q  <= numerator[WIDTH-1] ^ denominator[WIDTH-1];
         s0_nneg_q <= numerator[WIDTH-1];
         s0_dz_q   <= (denominator == '0);
         s0_den_q  <= mag_d_d;
         s0_dq_q   <= dq0_d;
         s0_tag_q  <= tag_in;
      end
   end

   assign st_v[0]    = s0_v_q;
   assign st_neg[0]  = s0_neg_q;
   assign st_nneg[0] = s0_nneg_q;
   assign st_dz[0]   = s0_dz_q;
   assign st_rem[0]  = '0;
   assign st_den[0]  = s0_den_q;
   assign st_dq[0]   = s0_dq_q;
   assign st_tag[0]  = s0_tag_q;

   for (genvar i = 0; i < NSTG; i++) begin : g_stg
      fx_div_stage #(
         .WIDTH (WIDTH),
         .NQ    (NQ),
         .BPS   (BPS),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .en_i   (en),
         .v_i    (st_v[i]),
         .rem_i  (st_rem[i]),
         .dq_i   (st_dq[i]),
         .den_i  (st_den[i]),
         .neg_i  (st_neg[i]),
         .nneg_i (st_nneg[i]),
         .dz_i   (st_dz[i]),
         .tag_i  (st_tag[i]),
         .v_o    (st_v[i+1]),
         .rem_o  (st_rem[i+1]),
         .dq_o   (st_dq[i+1]),
         .den_o  (st_den[i+1]),
         .neg_o  (st_neg[i+1]),
         .nneg_o (st_nneg[i+1]),
         .dz_o   (st_dz[i+1]),
         .tag_o  (st_tag[i+1])
      );
   end

   // Rounding happens on the magnitude so the saturation limit sees it.
   always_comb begin
      rnd = (ROUND != 0) &&
            ({st_rem[NSTG], 1'b0} >= {1'b0, st_den[NSTG]});
      qr  = {1'b0, st_dq[NSTG]} + {{NQ{1'b0}}, rnd};
      dz_d     = st_dz[NSTG];
      ovf_d    = 1'b0;
      result_d = '0;
      if (st_dz[NSTG]) begin
         result_d = st_nneg[NSTG] ? MINR : MAXR;
      end else if (st_neg[NSTG]) begin
         if (qr > NEG_LIM) begin
            result_d = MINR;
            ovf_d    = 1'b1;
         end else begin
            result_d = -qr[WIDTH-1:0];
         end
      end else begin
         if (qr > POS_LIM) begin
            result_d = MAXR;
            ovf_d    = 1'b1;
         end else begin
            result_d = qr[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out_q <= 1'b0;
         result_q    <= '0;
         tag_out_q   <= '0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (en) begin
         valid_out_q <= st_v[NSTG];
         result_q    <= result_d;
         tag_out_q   <= st_tag[NSTG];
         dz_q        <= dz_d;
         ovf_q       <= ovf_d;
      end
   end

   assign valid_out = valid_out_q;
   assign result    = result_q;
   assign tag_out   = tag_out_q;
   assign dz        = dz_q;
   assign ovf       = ovf_q;

endmodule
